msl_tx_arbiter: RTL and testbench

- Shares one MSL single-wire transmit line between P_NUM_REQ requesters.
- Round-robin arbitration; serializes the granted word onto o_msl_sda; enforces the inter-frame gap.
- Line format: idle high; start low; each data bit is one level segment; stop segment; gap high.
- Sits on the master side of the link, driving the line that msl_slave_receiver samples on its 1 ms tick.

---
 rtl/msl_tx_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_msl_tx_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/msl_tx_arbiter.sv
// Round-robin arbiter and serializer for the shared MSL single-wire transmit line.
// Define MSL_TX_FIXED_PRIO_EN for fixed-priority arbitration (lowest index wins).
module msl_tx_arbiter #(
    parameter int P_NUM_REQ     = 4,
    parameter int P_DATA_WIDTH  = 8,
    parameter int P_CLK_FREQ    = 50_000_000,
    parameter int P_TICK_HZ     = 1000,
    parameter int P_START_TICKS = 10,
    parameter int P_ONE_TICKS   = 8,
    parameter int P_ZERO_TICKS  = 4,
    parameter int P_STOP_TICKS  = 3,
    parameter int P_GAP_TICKS   = 24,
    localparam int OW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [P_NUM_REQ-1:0]              i_req,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_data,
    output logic [P_NUM_REQ-1:0]              o_gnt,
    output logic [P_NUM_REQ-1:0]              o_done,
    output logic                              o_busy,
    output logic [OW-1:0]                     o_owner,
    output logic                              o_msl_sda
);

    localparam int TICK_DIV = P_CLK_FREQ / P_TICK_HZ;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SEG_MAX1 = (P_START_TICKS > P_ONE_TICKS) ? P_START_TICKS : P_ONE_TICKS;
    localparam int SEG_MAX2 = (P_GAP_TICKS > P_STOP_TICKS) ? P_GAP_TICKS : P_STOP_TICKS;
    localparam int SEG_MAX  = (SEG_MAX1 > SEG_MAX2) ? SEG_MAX1 : SEG_MAX2;
    localparam int SW       = $clog2(SEG_MAX + 1);
    localparam int BW       = $clog2(P_DATA_WIDTH + 1);
    localparam logic [P_NUM_REQ-1:0] REQ_LSB = {{(P_NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_BITS  = 3'd3,
        S_STOP  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [TW-1:0]           tick_cnt_r;
    logic                    tick_s;
    logic                    sda_r, sda_nxt_s;
    logic [P_NUM_REQ-1:0]    gnt_r, gnt_nxt_s;
    logic [P_NUM_REQ-1:0]    done_r, done_nxt_s;
    logic                    busy_r, busy_nxt_s;
    logic [OW-1:0]           owner_r, owner_nxt_s;
    logic [OW-1:0]           ptr_r, ptr_nxt_s;
    logic [P_DATA_WIDTH-1:0] shift_r, shift_nxt_s;
    logic [SW-1:0]           seg_cnt_r, seg_nxt_s;
    logic [BW-1:0]           bit_cnt_r, bit_nxt_s;
    logic [SW-1:0]           seg_len_s;
    logic                    found_s;
    logic [OW-1:0]           win_s;

    assign tick_s = (tick_cnt_r == TW'(TICK_DIV - 1));

    // Free-running line tick divider.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Requester search starting at the round-robin pointer (or index 0 for fixed priority).
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        win_s   = '0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
`ifdef MSL_TX_FIXED_PRIO_EN
            idx = i;
`else
            idx = (int'(ptr_r) + i) % P_NUM_REQ;
`endif
            if (!found_s && i_req[idx]) begin
                found_s = 1'b1;
                win_s   = OW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Frame sequencer and arbitration register state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= S_IDLE;
            sda_r     <= 1'b1;
            gnt_r     <= '0;
            done_r    <= '0;
            busy_r    <= 1'b0;
            owner_r   <= '0;
            ptr_r     <= '0;
            shift_r   <= '0;
            seg_cnt_r <= '0;
            bit_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            sda_r     <= sda_nxt_s;
            gnt_r     <= gnt_nxt_s;
            done_r    <= done_nxt_s;
            busy_r    <= busy_nxt_s;
            owner_r   <= owner_nxt_s;
            ptr_r     <= ptr_nxt_s;
            shift_r   <= shift_nxt_s;
            seg_cnt_r <= seg_nxt_s;
            bit_cnt_r <= bit_nxt_s;
        end
    end

    // Next-state and output logic; the MSB of shift_r is always the bit on the line.
    always_comb begin
        state_nxt_s = state_r;
        sda_nxt_s   = sda_r;
        gnt_nxt_s   = '0;
        done_nxt_s  = '0;
        busy_nxt_s  = busy_r;
        owner_nxt_s = owner_r;
        ptr_nxt_s   = ptr_r;
        shift_nxt_s = shift_r;
        seg_nxt_s   = seg_cnt_r;
        bit_nxt_s   = bit_cnt_r;
        seg_len_s   = shift_r[P_DATA_WIDTH-1] ? SW'(P_ONE_TICKS - 1) : SW'(P_ZERO_TICKS - 1);

        case (state_r)
            S_IDLE: begin
                sda_nxt_s = 1'b1;
                if (found_s) begin
                    gnt_nxt_s   = REQ_LSB << win_s;
                    shift_nxt_s = i_data[int'(win_s)*P_DATA_WIDTH +: P_DATA_WIDTH];
                    owner_nxt_s = win_s;
                    busy_nxt_s  = 1'b1;
`ifdef MSL_TX_FIXED_PRIO_EN
                    ptr_nxt_s   = '0;
`else
                    ptr_nxt_s   = (win_s == OW'(P_NUM_REQ - 1)) ? '0 : win_s + OW'(1);
`endif
                    state_nxt_s = S_WAIT;
                end else begin
                    busy_nxt_s  = 1'b0;
                end
            end
            S_WAIT: begin
                if (tick_s) begin
                    sda_nxt_s   = 1'b0;
                    seg_nxt_s   = '0;
                    state_nxt_s = S_START;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_START: begin
                if (tick_s && seg_cnt_r == SW'(P_START_TICKS - 1)) begin
                    sda_nxt_s   = ~sda_r;
                    seg_nxt_s   = '0;
                    bit_nxt_s   = '0;
                    state_nxt_s = S_BITS;
                end else if (tick_s) begin
                    seg_nxt_s   = seg_cnt_r + SW'(1);
                end else begin
                    seg_nxt_s   = seg_cnt_r;
                end
            end
            S_BITS: begin
                if (tick_s && seg_cnt_r == seg_len_s) begin
                    sda_nxt_s   = ~sda_r;
                    seg_nxt_s   = '0;
                    shift_nxt_s = {shift_r[P_DATA_WIDTH-2:0], 1'b0};
                    if (bit_cnt_r == BW'(P_DATA_WIDTH - 1)) begin
                        bit_nxt_s   = '0;
                        state_nxt_s = S_STOP;
                    end else begin
                        bit_nxt_s   = bit_cnt_r + BW'(1);
                    end
                end else if (tick_s) begin
                    seg_nxt_s   = seg_cnt_r + SW'(1);
                end else begin
                    seg_nxt_s   = seg_cnt_r;
                end
            end
            S_STOP: begin
                if (tick_s && seg_cnt_r == SW'(P_STOP_TICKS - 1)) begin
                    sda_nxt_s   = 1'b1;
                    seg_nxt_s   = '0;
                    state_nxt_s = S_GAP;
                end else if (tick_s) begin
                    seg_nxt_s   = seg_cnt_r + SW'(1);
                end else begin
                    seg_nxt_s   = seg_cnt_r;
                end
            end
            S_GAP: begin
                sda_nxt_s = 1'b1;
                if (tick_s && seg_cnt_r == SW'(P_GAP_TICKS - 1)) begin
                    done_nxt_s  = REQ_LSB << owner_r;
                    busy_nxt_s  = 1'b0;
                    seg_nxt_s   = '0;
                    state_nxt_s = S_IDLE;
                end else if (tick_s) begin
                    seg_nxt_s   = seg_cnt_r + SW'(1);
                end else begin
                    seg_nxt_s   = seg_cnt_r;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                sda_nxt_s   = 1'b1;
                busy_nxt_s  = 1'b0;
                seg_nxt_s   = '0;
                bit_nxt_s   = '0;
            end
        endcase
    end

    assign o_gnt     = gnt_r;
    assign o_done    = done_r;
    assign o_busy    = busy_r;
    assign o_owner   = owner_r;
    assign o_msl_sda = sda_r;

endmodule

// File: tb/tb_msl_tx_arbiter.sv
// Directed bench for msl_tx_arbiter: tick every 10 clocks, line decoded by measuring segment lengths.
module tb_msl_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] data = 32'h0;
    logic [3:0]  gnt, done;
    logic        busy;
    logic [1:0]  owner;
    logic        sda;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int gnt2_cnt = 0;
    int t;
    int n;

    msl_tx_arbiter #(
        .P_NUM_REQ(4), .P_DATA_WIDTH(8), .P_CLK_FREQ(1000), .P_TICK_HZ(100),
        .P_START_TICKS(10), .P_ONE_TICKS(8), .P_ZERO_TICKS(4),
        .P_STOP_TICKS(3), .P_GAP_TICKS(24)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data),
        .o_gnt(gnt), .o_done(done), .o_busy(busy), .o_owner(owner), .o_msl_sda(sda)
    );

    always #5 clk = ~clk;

    // Event counters for pulses that must never occur in some windows.
    always @(negedge clk) begin
        if (done != 4'b0000) done_cnt++;
        if (gnt[2]) gnt2_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clocks spent at the current line level, sampled on falling edges.
    task automatic seg(output int len);
        logic l;
        l = sda;
        len = 0;
        while (sda === l && len < 2000) begin
            @(negedge clk);
            len++;
        end
    endtask

    // Slave-side decoder: expects a full frame, then o_done to the given owner.
    task automatic frame(input int own, input logic [7:0] exp, output int ticks);
        int len, tot;
        logic [7:0] w;
        bit bad;
        len = 0;
        while (sda !== 1'b0 && len < 200) begin
            @(negedge clk);
            len++;
        end
        check("start_fall", sda, 1'b0);
        seg(len);
        check("start_len", len, 100);
        tot = len;
        bad = 1'b0;
        w = 8'h00;
        for (int b = 0; b < 8; b++) begin
            seg(len);
            tot += len;
            w = {w[6:0], (len == 80)};
            if (len != 80 && len != 40) bad = 1'b1;
        end
        check("seg_legal", bad, 1'b0);
        check("word", w, exp);
        len = 0;
        while (done === 4'b0000 && len < 1000) begin
            @(negedge clk);
            len++;
        end
        tot += len;
        check("tail_len", len, 270);
        check("done", done, 4'b0001 << own);
        check("busy_clear", busy, 1'b0);
        check("owner", owner, own[1:0]);
        ticks = tot / 10;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sda", sda, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_done", done, 4'b0000);
        check("rst_owner", owner, 2'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_sda", sda, 1'b1);

`ifdef MSL_TX_FIXED_PRIO_EN
        data = 32'h96_E1_5A_3C;
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fp_gnt", gnt, 4'b0010);
            frame(1, 8'h5A, t);
            check("fp_no_b2b", gnt, 4'b0000);
        end
        req = 4'b0000;
`else
        data = 32'h96_E1_5A_3C;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_gnt", gnt, 4'b0001 << (k % 4));
            check("rr_busy", busy, 1'b1);
            frame(k % 4, data[(k % 4)*8 +: 8], t);
            check("rr_no_b2b", gnt, 4'b0000);
        end
        req = 4'b0000;
`endif
        repeat (5) @(negedge clk);

        // Single request from requester 1 with 8'hA5.
        data[15:8] = 8'hA5;
        req = 4'b0010;
        @(negedge clk);
        check("single_gnt", gnt, 4'b0010);
        check("single_owner", owner, 2'd1);
        req = 4'b0000;
        @(negedge clk);
        check("gnt_pulse", gnt, 4'b0000);
        frame(1, 8'hA5, t);
        check("a5_ticks", t, 85);

        // Withdrawn request from requester 2 while requester 0 is busy.
        repeat (4) @(negedge clk);
        gnt2_cnt = 0;
        req = 4'b0001;
        @(negedge clk);
        check("wd_gnt", gnt, 4'b0001);
        req = 4'b0000;
        fork
            begin
                repeat (30) @(negedge clk);
                req[2] = 1'b1;
                repeat (3) @(negedge clk);
                req[2] = 1'b0;
            end
        join_none
        frame(0, 8'h3C, t);
        repeat (50) @(negedge clk);
        check("wd_never_gnt2", gnt2_cnt, 0);
        check("wd_idle", busy, 1'b0);

        // All-zeros and all-ones frames.
        data[15:8] = 8'h00;
        req = 4'b0010;
        @(negedge clk);
        check("z_gnt", gnt, 4'b0010);
        req = 4'b0000;
        frame(1, 8'h00, t);
        check("zeros_ticks", t, 69);
        repeat (3) @(negedge clk);
        data[15:8] = 8'hFF;
        req = 4'b0010;
        @(negedge clk);
        check("o_gnt", gnt, 4'b0010);
        req = 4'b0000;
        frame(1, 8'hFF, t);
        check("ones_ticks", t, 101);

        // Reset in the middle of the data bits.
        repeat (3) @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        check("mr_gnt", gnt, 4'b0001);
        req = 4'b0000;
        n = 0;
        while (sda !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (150) @(negedge clk);
        check("mr_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_sda_async", sda, 1'b1);
        check("mr_busy", busy, 1'b0);
        done_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1500) @(negedge clk);
        check("mr_no_done", done_cnt, 0);
        check("mr_sda_idle", sda, 1'b1);
        check("mr_owner", owner, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
